// File: rtl/multibank_pkt_fifo_pkg.sv
// Shared types and defaults for the multi-bank packet FIFO.
package multibank_pkt_fifo_pkg;

    typedef enum logic [1:0] {
        BANK_FREE,
        BANK_FILLING,
        BANK_FULL,
        BANK_DRAINING
    } bank_state_e;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_BANK_DEPTH = 11552;
    localparam int DEF_ADDR_WIDTH = 14;
    localparam int DEF_NUM_BANKS  = 4;
    localparam int DROP_W         = 16;

    // A zero or oversized request means "use the whole bank".
    function automatic int clamp_len(input int req, input int depth);
        return ((req == 0) || (req > depth)) ? depth : req;
    endfunction

endpackage

// File: rtl/multibank_pkt_fifo_if.sv
// Write, read and status signals of the multi-bank packet FIFO.
interface multibank_pkt_fifo_if
    import multibank_pkt_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int NUM_BANKS  = DEF_NUM_BANKS
) ();
    localparam int BANK_W = $clog2(NUM_BANKS);

    logic                  wr_en;
    logic [DATA_WIDTH-1:0] din;
    logic [ADDR_WIDTH:0]   pkt_len;
    logic                  flush;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] dout;
    logic                  valid;
    logic                  package_ready;
    logic                  rd_done;
    logic                  empty;
    logic [BANK_W:0]       full_count;
    logic [BANK_W-1:0]     wr_bank;
    logic [BANK_W-1:0]     rd_bank;
    logic                  overflow;
    logic [DROP_W-1:0]     drop_count;

    modport master (
        output wr_en, din, pkt_len, flush, rd_en,
        input  dout, valid, package_ready, rd_done, empty, full_count,
               wr_bank, rd_bank, overflow, drop_count
    );

    modport slave (
        input  wr_en, din, pkt_len, flush, rd_en,
        output dout, valid, package_ready, rd_done, empty, full_count,
               wr_bank, rd_bank, overflow, drop_count
    );

endinterface

// File: rtl/bank_ram.sv
// Single-clock simple dual-port RAM with a registered read port.
module bank_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // NOTE: no reset on the array or read register so the RAM maps onto block memory;
    // bank state alone decides whether contents are meaningful.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/multibank_pkt_fifo.sv
// Packet FIFO built from NUM_BANKS RAM banks; each bank holds one package and banks drain in fill order.
module multibank_pkt_fifo
    import multibank_pkt_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int BANK_DEPTH = DEF_BANK_DEPTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int NUM_BANKS  = DEF_NUM_BANKS
) (
    input logic                 sys_clk,
    input logic                 rst_n,
    multibank_pkt_fifo_if.slave bus
);
    localparam int BANK_W = $clog2(NUM_BANKS);
    localparam int LEN_W  = ADDR_WIDTH + 1;

    bank_state_e           state [NUM_BANKS];
    logic [LEN_W-1:0]      len   [NUM_BANKS];
    logic [DATA_WIDTH-1:0] ram_q [NUM_BANKS];

    logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;
    logic [BANK_W-1:0]     wr_bank, rd_bank, rd_sel;
    logic [BANK_W:0]       full_count;
    logic [DROP_W-1:0]     drop_count;
    logic                  overflow, valid, rd_done;

    bank_state_e      wr_state, rd_state;
    logic             wr_open, wr_fire, wr_drop, wr_last;
    logic             rd_fire, rd_last;
    logic [LEN_W-1:0] wr_len, rd_len;

    function automatic logic [BANK_W-1:0] next_bank(input logic [BANK_W-1:0] b);
        return (b == BANK_W'(NUM_BANKS - 1)) ? '0 : b + BANK_W'(1);
    endfunction

    always_comb begin
        wr_state = state[wr_bank];
        rd_state = state[rd_bank];
        wr_open  = (wr_state == BANK_FREE) || (wr_state == BANK_FILLING);
        wr_fire  = bus.wr_en && !bus.flush && wr_open;
        wr_drop  = bus.wr_en && !bus.flush && !wr_open;
        // A FREE bank uses the live pkt_len; once filling, the latched length rules.
        wr_len   = (wr_state == BANK_FREE)
                   ? LEN_W'(clamp_len(int'(bus.pkt_len), BANK_DEPTH))
                   : len[wr_bank];
        wr_last  = (LEN_W'(wr_addr) == wr_len - LEN_W'(1));
        rd_fire  = bus.rd_en && ((rd_state == BANK_FULL) || (rd_state == BANK_DRAINING));
        rd_len   = len[rd_bank];
        rd_last  = (LEN_W'(rd_addr) == rd_len - LEN_W'(1));
    end

    // NOTE: package length needs no reset; it is always relatched on the FREE->FILLING edge.
    always_ff @(posedge sys_clk) begin
        if (wr_fire && (wr_state == BANK_FREE)) len[wr_bank] <= wr_len;
    end

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_BANKS; i++) state[i] <= BANK_FREE;
            wr_addr    <= '0;
            rd_addr    <= '0;
            wr_bank    <= '0;
            rd_bank    <= '0;
            rd_sel     <= '0;
            full_count <= '0;
            drop_count <= '0;
            overflow   <= 1'b0;
            valid      <= 1'b0;
            rd_done    <= 1'b0;
        end else begin
            if (bus.flush) begin
                if (wr_state == BANK_FILLING) state[wr_bank] <= BANK_FREE;
                wr_addr <= '0;
            end else if (wr_fire) begin
                if (wr_last) begin
                    state[wr_bank] <= BANK_FULL;
                    wr_addr        <= '0;
                    wr_bank        <= next_bank(wr_bank);
                end else begin
                    state[wr_bank] <= BANK_FILLING;
                    wr_addr        <= wr_addr + ADDR_WIDTH'(1);
                end
            end

            if (wr_drop) begin
                overflow <= 1'b1;
                if (drop_count != '1) drop_count <= drop_count + DROP_W'(1);
            end

            // Write only touches FREE/FILLING banks and read only FULL/DRAINING, so indices never collide.
            if (rd_fire) begin
                rd_sel <= rd_bank;
                if (rd_last) begin
                    state[rd_bank] <= BANK_FREE;
                    rd_addr        <= '0;
                    rd_bank        <= next_bank(rd_bank);
                end else begin
                    state[rd_bank] <= BANK_DRAINING;
                    rd_addr        <= rd_addr + ADDR_WIDTH'(1);
                end
            end
            valid   <= rd_fire;
            rd_done <= rd_fire && rd_last;

            case ({wr_fire && wr_last, rd_fire && rd_last})
                2'b10:   full_count <= full_count + (BANK_W + 1)'(1);
                2'b01:   full_count <= full_count - (BANK_W + 1)'(1);
                default: ;
            endcase
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        bank_ram #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (BANK_DEPTH),
            .ADDR_WIDTH (ADDR_WIDTH)
        ) u_ram (
            .clk   (sys_clk),
            .we    (wr_fire && (wr_bank == BANK_W'(b))),
            .waddr (wr_addr),
            .wdata (bus.din),
            .re    (rd_fire && (rd_bank == BANK_W'(b))),
            .raddr (rd_addr),
            .rdata (ram_q[b])
        );
    end

    assign bus.dout          = ram_q[rd_sel];
    assign bus.valid         = valid;
    assign bus.rd_done       = rd_done;
    assign bus.package_ready = (full_count != '0);
    assign bus.empty         = (full_count == '0);
    assign bus.full_count    = full_count;
    assign bus.wr_bank       = wr_bank;
    assign bus.rd_bank       = rd_bank;
    assign bus.overflow      = overflow;
    assign bus.drop_count    = drop_count;

endmodule

// File: doc/multibank_pkt_fifo.md
MULTIBANK_PKT_FIFO -- requirements
Module: multibank_pkt_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 8, byte lane width.
REQ-002 Parameter BANK_DEPTH, default 11552, words per bank.
REQ-003 Parameter ADDR_WIDTH, default 14, bank address width; BANK_DEPTH <= 2**ADDR_WIDTH.
REQ-004 Parameter NUM_BANKS, default 4, legal range 2..8; BANK_W = clog2(NUM_BANKS).
REQ-005 sys_clk  in  1  single clock; all logic on rising edge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 wr_en  in  1  write strobe for din.
REQ-008 din  in  DATA_WIDTH  write data.
REQ-009 pkt_len  in  ADDR_WIDTH+1  package length in words; sampled at start of each bank fill.
REQ-010 flush  in  1  discards the partially filled bank.
REQ-011 rd_en  in  1  read strobe.
REQ-012 dout  out  DATA_WIDTH  read data.
REQ-013 valid  out  1  dout qualifier.
REQ-014 package_ready  out  1  at least one bank FULL.
REQ-015 rd_done  out  1  single-cycle pulse, last word of a package read.
REQ-016 empty  out  1  no FULL or DRAINING bank.
REQ-017 full_count  out  BANK_W+1  banks FULL or DRAINING.
REQ-018 wr_bank, rd_bank  out  BANK_W each  current write/read bank index.
REQ-019 overflow  out  1  sticky; a write was dropped.
REQ-020 drop_count  out  16  dropped-word count, saturating at 16'hFFFF.

Function
REQ-021 Each bank SHALL hold state FREE, FILLING, FULL or DRAINING.
REQ-022 wr_en while bank[wr_bank] is FREE or FILLING SHALL write din at wr_addr, increment wr_addr, and set the bank to FILLING.
REQ-023 On a FREE->FILLING transition the bank SHALL latch pkt_len; values 0 or >BANK_DEPTH SHALL clamp to BANK_DEPTH.
REQ-024 A write to address len-1 SHALL mark the bank FULL, reset wr_addr to 0, and advance wr_bank modulo NUM_BANKS in the same cycle.
REQ-025 wr_en while bank[wr_bank] is FULL or DRAINING SHALL drop din, set overflow, and increment drop_count (saturating).
REQ-026 package_ready SHALL be high whenever full_count is greater than 0; it is a level, not a pulse.
REQ-027 rd_en with bank[rd_bank] FULL or DRAINING SHALL read rd_addr, set the bank to DRAINING, and present dout with valid=1 exactly one cycle later.
REQ-028 rd_en with no readable bank SHALL be ignored; valid=0 next cycle.
REQ-029 A read of address len-1 SHALL free the bank, reset rd_addr, advance rd_bank modulo NUM_BANKS, and pulse rd_done aligned with the valid of that last word.
REQ-030 A package completing on write and a package freeing on read in the same cycle SHALL leave full_count unchanged.
REQ-031 Banks SHALL be read in the same order they were filled; read and write SHALL never target the same bank.
REQ-032 flush SHALL return a FILLING bank to FREE and zero wr_addr; FULL and DRAINING banks are unaffected; flush has priority over a coincident wr_en.
REQ-033 Back-to-back rd_en SHALL sustain one word per cycle, including across a bank boundary.

Reset
REQ-034 rst_n low at a clock edge SHALL set all banks FREE; zero wr_addr, rd_addr, wr_bank, rd_bank, full_count and drop_count; and clear overflow, valid and rd_done. empty SHALL be 1 and package_ready 0.
REQ-035 Reset mid-package SHALL discard all buffered data with no residual rd_done or valid pulse; RAM contents need not be cleared.

Structure
REQ-036 Package multibank_pkt_fifo_pkg SHALL hold the bank-state enum, the default parameter constants, and the drop_count width.
REQ-037 Sub-module bank_ram (single-clock simple dual-port RAM, registered read, DATA_WIDTH x BANK_DEPTH) SHALL be instantiated NUM_BANKS times through a generate loop; output muxing by a registered rd_bank copy.

Verification
REQ-038 NUM_BANKS=4, pkt_len=16: write 16 words 0..15 -> package_ready=1 on the cycle after the last write, wr_bank=1, full_count=1.
REQ-039 Continuous rd_en over 2 full banks -> 32 valid words in fill order, rd_done twice (on words 15 and 31), no gap at the bank boundary.
REQ-040 Fill all 4 banks, then write 5 more words -> overflow=1, drop_count=5, stored data intact.
REQ-041 Last write of bank 1 and last read of bank 0 in the same cycle -> full_count stays 1, rd_bank=1, wr_bank=2.
REQ-042 Write 7 words, assert flush, then reset low mid-read of another bank -> bank returns FREE, wr_addr=0; after reset, empty=1, no valid.
REQ-043 pkt_len=0 -> the bank fills to BANK_DEPTH before FULL.
